traffic_light_ctrl: RTL and testbench
=====================================

// Module: traffic_light_ctrl
// PURPOSE
//  Generates light1..light4 for the intersection car counter. Those lights drive the
//  counter's queue movements; this block is the producer of that interface.
//  Runs a two-axis FSM: axis A (light1, light3) and axis B (light2, light4), each with
//  green/yellow/all-red. Green length adapts to the per-axis queue totals fed back from
//  the counter. Exposes phase and seconds-remaining for the 7-seg display.
// PARAMETERS
//  TICK_DIV    100_000_000  clk cycles per 1 s tick; the prescaler is $clog2(TICK_DIV) bits
//  GREEN_MIN   5            minimum green, s (>=1)
//  GREEN_MAX   15           maximum green, s (>=GREEN_MIN)
//  YELLOW_SEC  3            yellow duration, s (>=1)
//  ALLRED_SEC  1            all-red clearance, s (>=1)
//  PED_SEC     8            pedestrian walk, s (PED_EN only)
// PORTS
//  clk       in   1  system clock
//  rst       in   1  synchronous reset, active-low
//  hold      in   1  1 = freeze prescaler and FSM
//  queue_a   in   8  cars waiting on axis A (sum from counter, unsigned)
//  queue_b   in   8  cars waiting on axis B
//  light1    out  1  axis A go, lane 1
//  light3    out  1  axis A go, lane 3
//  light2    out  1  axis B go, lane 2
//  light4    out  1  axis B go, lane 4
//  yellow_a  out  1  axis A yellow
//  yellow_b  out  1  axis B yellow
//  phase     out  3  0 A_GREEN, 1 A_YELLOW, 2 A_ALLRED, 3 B_GREEN, 4 B_YELLOW, 5 B_ALLRED, 6 PED
//  remain    out  8  seconds left in the current phase
//  tick      out  1  one-cycle pulse per second
// BEHAVIOUR
//  - Clock is clk; reset is synchronous, active-low (rst=0 sampled at posedge).
//  - Reset values: phase=A_GREEN, remain=GREEN_MIN, light1=light3=1, light2=light4=0,
//    yellow_a=yellow_b=0, tick=0, prescaler=0, green elapsed g_el=0.
//  - Reset mid-operation has the same effect from any state; no partial phase survives.
//  - Prescaler counts 0..TICK_DIV-1 and wraps.
//    - The edge where prescaler==TICK_DIV-1 is the tick edge.
//    - On that edge: tick<=1 for one cycle; FSM, remain and g_el update. All outputs are registered.
//  - hold=1: prescaler, FSM, remain and g_el are frozen, tick=0; outputs keep their values.
//  - Green (own axis X, other axis Y), on each tick:
//    - g_el<=g_el+1.
//    - ext = (q_X!=0) && (q_X>=q_Y) && (g_el+1 < GREEN_MAX).
//    - If g_el+1 < GREEN_MIN: remain<=GREEN_MIN-(g_el+1).
//    - Else if ext: remain<=1 (1 s extension).
//    - Else: go to X_YELLOW, remain<=YELLOW_SEC.
//    - The green never exceeds GREEN_MAX ticks.
//  - Yellow/all-red/PED on each tick: if remain==1, go to the next state with its reload;
//    else remain<=remain-1.
//  - Sequence: A_GREEN>A_YELLOW>A_ALLRED>B_GREEN>B_YELLOW>B_ALLRED>A_GREEN.
//    - Entering a green: g_el<=0, remain<=GREEN_MIN.
//    - Entering all-red: remain<=ALLRED_SEC.
//  - Lights per phase:
//    - X_GREEN: the X pair is 1, everything else 0.
//    - X_YELLOW: the X pair is 0, yellow_X=1.
//    - ALLRED and PED: all lights and yellows are 0.
//    - At most one axis is ever 1.
//  - Queue inputs are sampled only on tick edges; equal nonzero queues favour the axis
//    currently green.
// CONFIGURATION
//  PED_EN defined:
//    - Adds input ped_req (1 bit) and output ped_walk (1 bit).
//    - A rising edge of ped_req sets ped_pend. Repeated presses while pending have no
//      further effect.
//    - When either ALLRED expires with ped_pend=1: enter PED, remain<=PED_SEC, clear
//      ped_pend. ped_walk=1 only in PED.
//    - When PED expires, go to the green that the ALLRED would have entered.
//    - Reset clears ped_pend and ped_walk.
//  PED_EN undefined: those ports do not exist, phase 6 is unreachable, and ALLRED goes
//    directly to the next green.
// TESTING (TICK_DIV=4, GREEN_MIN=3, GREEN_MAX=6, YELLOW_SEC=2, ALLRED_SEC=1, PED_SEC=2)
//  1. Reset, queues 0.
//     -> A_GREEN 12 clk, A_YELLOW 8, A_ALLRED 4, B_GREEN 12, B_YELLOW 8, B_ALLRED 4.
//     -> Back to A_GREEN at clk 48. tick every 4 clk; remain shows 3,2,1 during green.
//  2. queue_a=5, queue_b=2 held.
//     -> A green lasts 6 ticks (capped by GREEN_MAX), remain 3,2,1,1,1,1, then A_YELLOW remain=2.
//  3. queue_a=2, queue_b=7.
//     -> A green ends after 3 ticks.
//     -> B green then extends to 6 ticks.
//  4. hold=1 for 20 clk mid A_YELLOW.
//     -> phase, remain and prescaler unchanged; tick=0.
//     -> Timing resumes exactly from the held point.
//  5. rst=0 for 1 clk during B_GREEN.
//     -> Next edge: phase=0, remain=3, light1=light3=1, light2=light4=0.
//  6. PED_EN: ped_req 0->1 during A_GREEN.
//     -> After A_ALLRED: PED for 8 clk, ped_walk=1, all lights 0.
//     -> Then B_GREEN; a second request during PED is ignored.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-axis adaptive traffic light FSM with 1 s prescaler
// Optional pedestrian phase is compiled in when the PED_EN macro is defined.
module traffic_light_ctrl #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int GREEN_MIN  = 5,
    parameter int GREEN_MAX  = 15,
    parameter int YELLOW_SEC = 3,
    parameter int ALLRED_SEC = 1,
    parameter int PED_SEC    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic [7:0] queue_a,
    input  logic [7:0] queue_b,
`ifdef PED_EN
    input  logic       ped_req,
    output logic       ped_walk,
`endif
    output logic       light1,
    output logic       light3,
    output logic       light2,
    output logic       light4,
    output logic       yellow_a,
    output logic       yellow_b,
    output logic [2:0] phase,
    output logic [7:0] remain,
    output logic       tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0] GMIN8 = 8'(GREEN_MIN);
    localparam logic [7:0] GMAX8 = 8'(GREEN_MAX);
    localparam logic [7:0] YEL8  = 8'(YELLOW_SEC);
    localparam logic [7:0] AR8   = 8'(ALLRED_SEC);

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        A_ALLRED = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        B_ALLRED = 3'd5,
        PED      = 3'd6
    } phase_t;

    phase_t        phase_q, phase_d;
    logic [7:0]    remain_q, remain_d;
    logic [7:0]    g_el_q, g_el_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          la_q, la_d;
    logic          lb_q, lb_d;
    logic          ya_q, ya_d;
    logic          yb_q, yb_d;

    logic          is_tick;
    logic [7:0]    g_next;
    logic [7:0]    q_own;
    logic [7:0]    q_oth;
    logic          ext;
    phase_t        next_green;

`ifdef PED_EN
    localparam logic [7:0] PED8 = 8'(PED_SEC);
    logic   ped_req_q;
    logic   ped_pend_q, ped_pend_d;
    logic   ped_walk_q, ped_walk_d;
    phase_t ped_ret_q, ped_ret_d;
`endif

    always_comb begin
        phase_d    = phase_q;
        remain_d   = remain_q;
        g_el_d     = g_el_q;
        presc_d    = presc_q;
        tick_d     = 1'b0;
        is_tick    = !hold && (presc_q == PRESC_LAST);
        g_next     = g_el_q + 8'd1;
        q_own      = (phase_q == A_GREEN) ? queue_a : queue_b;
        q_oth      = (phase_q == A_GREEN) ? queue_b : queue_a;
        ext        = (q_own != 8'd0) && (q_own >= q_oth) && (g_next < GMAX8);
        next_green = (phase_q == A_ALLRED) ? B_GREEN : A_GREEN;
`ifdef PED_EN
        ped_pend_d = ped_pend_q;
        ped_ret_d  = ped_ret_q;
`endif

        if (!hold) begin
            presc_d = is_tick ? '0 : presc_q + 1'b1;
        end

        if (is_tick) begin
            tick_d = 1'b1;
            unique case (phase_q)
                A_GREEN, B_GREEN: begin
                    g_el_d = g_next;
                    if (g_next < GMIN8) begin
                        remain_d = GMIN8 - g_next;
                    end else if (ext) begin
                        remain_d = 8'd1;
                    end else begin
                        phase_d  = (phase_q == A_GREEN) ? A_YELLOW : B_YELLOW;
                        remain_d = YEL8;
                    end
                end
                A_YELLOW, B_YELLOW: begin
                    if (remain_q == 8'd1) begin
                        phase_d  = (phase_q == A_YELLOW) ? A_ALLRED : B_ALLRED;
                        remain_d = AR8;
                    end else begin
                        remain_d = remain_q - 8'd1;
                    end
                end
                A_ALLRED, B_ALLRED: begin
                    if (remain_q == 8'd1) begin
`ifdef PED_EN
                        if (ped_pend_q) begin
                            phase_d    = PED;
                            remain_d   = PED8;
                            ped_ret_d  = next_green;
                            ped_pend_d = 1'b0;
                        end else begin
                            phase_d  = next_green;
                            remain_d = GMIN8;
                            g_el_d   = 8'd0;
                        end
`else
                        phase_d  = next_green;
                        remain_d = GMIN8;
                        g_el_d   = 8'd0;
`endif
                    end else begin
                        remain_d = remain_q - 8'd1;
                    end
                end
                default: begin
`ifdef PED_EN
                    if (remain_q == 8'd1) begin
                        phase_d  = ped_ret_q;
                        remain_d = GMIN8;
                        g_el_d   = 8'd0;
                    end else begin
                        remain_d = remain_q - 8'd1;
                    end
`else
                    // PED is unreachable here; recover to a known green
                    phase_d  = A_GREEN;
                    remain_d = GMIN8;
                    g_el_d   = 8'd0;
`endif
                end
            endcase
        end

`ifdef PED_EN
        // Presses during the walk itself are dropped, not queued for the next cycle
        if (ped_req && !ped_req_q && (phase_q != PED) && (phase_d != PED)) begin
            ped_pend_d = 1'b1;
        end
        ped_walk_d = (phase_d == PED);
`endif

        la_d = (phase_d == A_GREEN);
        lb_d = (phase_d == B_GREEN);
        ya_d = (phase_d == A_YELLOW);
        yb_d = (phase_d == B_YELLOW);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q  <= A_GREEN;
            remain_q <= GMIN8;
            g_el_q   <= 8'd0;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            la_q     <= 1'b1;
            lb_q     <= 1'b0;
            ya_q     <= 1'b0;
            yb_q     <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            remain_q <= remain_d;
            g_el_q   <= g_el_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            la_q     <= la_d;
            lb_q     <= lb_d;
            ya_q     <= ya_d;
            yb_q     <= yb_d;
        end
    end

`ifdef PED_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            ped_req_q  <= 1'b0;
            ped_pend_q <= 1'b0;
            ped_walk_q <= 1'b0;
            ped_ret_q  <= A_GREEN;
        end else begin
            ped_req_q  <= ped_req;
            ped_pend_q <= ped_pend_d;
            ped_walk_q <= ped_walk_d;
            ped_ret_q  <= ped_ret_d;
        end
    end

    assign ped_walk = ped_walk_q;
`endif

    assign light1   = la_q;
    assign light3   = la_q;
    assign light2   = lb_q;
    assign light4   = lb_q;
    assign yellow_a = ya_q;
    assign yellow_b = yb_q;
    assign phase    = phase_q;
    assign remain   = remain_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - directed self-checking bench for traffic_light_ctrl
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold;
    logic [7:0] queue_a;
    logic [7:0] queue_b;
    logic       light1, light3, light2, light4;
    logic       yellow_a, yellow_b;
    logic [2:0] phase;
    logic [7:0] remain;
    logic       tick;
`ifdef PED_EN
    logic       ped_req;
    logic       ped_walk;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int k_cnt  = 0;

    // Per-tick expectations for an idle intersection (queues 0), tick index 0..12
    int ph_tab [0:12] = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
    int rm_tab [0:12] = '{3, 2, 1, 2, 1, 1, 3, 2, 1, 2, 1, 1, 3};
    int rm_ext [0:6]  = '{3, 2, 1, 1, 1, 1, 2};

    traffic_light_ctrl #(
        .TICK_DIV  (4),
        .GREEN_MIN (3),
        .GREEN_MAX (6),
        .YELLOW_SEC(2),
        .ALLRED_SEC(1),
        .PED_SEC   (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .queue_a (queue_a),
        .queue_b (queue_b),
`ifdef PED_EN
        .ped_req (ped_req),
        .ped_walk(ped_walk),
`endif
        .light1  (light1),
        .light3  (light3),
        .light2  (light2),
        .light4  (light4),
        .yellow_a(yellow_a),
        .yellow_b(yellow_b),
        .phase   (phase),
        .remain  (remain),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge clk);
            k_cnt++;
        end
    endtask

    task automatic do_reset(input logic [7:0] qa, input logic [7:0] qb);
        @(negedge clk);
        rst     = 1'b0;
        hold    = 1'b0;
        queue_a = qa;
        queue_b = qb;
`ifdef PED_EN
        ped_req = 1'b0;
`endif
        @(negedge clk);
        rst   = 1'b1;
        k_cnt = 0;
    endtask

    task automatic test_reset;
        do_reset(8'd0, 8'd0);
        n_chk++; if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase got %0d want 0", phase); end
        n_chk++; if (remain !== 8'd3) begin n_fail++; $display("FAIL reset_remain got %0d want 3", remain); end
        n_chk++; if ({light1, light3, light2, light4} !== 4'b1100) begin n_fail++; $display("FAIL reset_lights got %b want 1100", {light1, light3, light2, light4}); end
        n_chk++; if ({yellow_a, yellow_b, tick} !== 3'b000) begin n_fail++; $display("FAIL reset_yel_tick got %b want 000", {yellow_a, yellow_b, tick}); end
`ifdef PED_EN
        n_chk++; if (ped_walk !== 1'b0) begin n_fail++; $display("FAIL reset_ped_walk got %b want 0", ped_walk); end
`endif
    endtask

    task automatic test_basic_cycle;
        int   t;
        logic [2:0] eph;
        logic et;
        do_reset(8'd0, 8'd0);
        for (int k = 1; k <= 48; k++) begin
            adv(1);
            t   = k / 4;
            eph = 3'(ph_tab[t]);
            et  = ((k % 4) == 0);
            n_chk++; if (phase !== eph) begin n_fail++; $display("FAIL cycle_phase k=%0d got %0d want %0d", k, phase, eph); end
            n_chk++; if (remain !== 8'(rm_tab[t])) begin n_fail++; $display("FAIL cycle_remain k=%0d got %0d want %0d", k, remain, rm_tab[t]); end
            n_chk++; if (tick !== et) begin n_fail++; $display("FAIL cycle_tick k=%0d got %b want %b", k, tick, et); end
            n_chk++; if ({light1, light3, light2, light4, yellow_a, yellow_b} !==
                         {eph == 3'd0, eph == 3'd0, eph == 3'd3, eph == 3'd3, eph == 3'd1, eph == 3'd4}) begin
                n_fail++;
                $display("FAIL cycle_lights k=%0d got %b phase_exp %0d", k,
                         {light1, light3, light2, light4, yellow_a, yellow_b}, eph);
            end
        end
    endtask

    task automatic test_extend_a;
        do_reset(8'd5, 8'd2);
        adv(1);
        for (int t = 0; t <= 6; t++) begin
            if (t > 0) adv(4);
            n_chk++; if (phase !== ((t < 6) ? 3'd0 : 3'd1)) begin n_fail++; $display("FAIL ext_phase t=%0d got %0d", t, phase); end
            n_chk++; if (remain !== 8'(rm_ext[t])) begin n_fail++; $display("FAIL ext_remain t=%0d got %0d want %0d", t, remain, rm_ext[t]); end
        end
    endtask

    task automatic test_extend_b;
        do_reset(8'd2, 8'd7);
        adv(13);
        n_chk++; if (phase !== 3'd1) begin n_fail++; $display("FAIL qb_a_short got %0d want 1", phase); end
        adv(12);
        n_chk++; if (phase !== 3'd3 || remain !== 8'd3) begin n_fail++; $display("FAIL qb_b_enter got %0d/%0d want 3/3", phase, remain); end
        n_chk++; if ({light1, light2, light4} !== 3'b011) begin n_fail++; $display("FAIL qb_b_lights got %b want 011", {light1, light2, light4}); end
        adv(8);
        n_chk++; if (phase !== 3'd3 || remain !== 8'd1) begin n_fail++; $display("FAIL qb_b_t8 got %0d/%0d want 3/1", phase, remain); end
        adv(12);
        n_chk++; if (phase !== 3'd3 || remain !== 8'd1) begin n_fail++; $display("FAIL qb_b_t11 got %0d/%0d want 3/1", phase, remain); end
        adv(4);
        n_chk++; if (phase !== 3'd4 || remain !== 8'd2 || yellow_b !== 1'b1) begin n_fail++; $display("FAIL qb_b_yellow got %0d/%0d/%b want 4/2/1", phase, remain, yellow_b); end
    endtask

    task automatic test_hold;
        do_reset(8'd0, 8'd0);
        adv(14);
        n_chk++; if (phase !== 3'd1 || remain !== 8'd2) begin n_fail++; $display("FAIL hold_pre got %0d/%0d want 1/2", phase, remain); end
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            adv(1);
            n_chk++; if (phase !== 3'd1 || remain !== 8'd2 || tick !== 1'b0) begin
                n_fail++; $display("FAIL hold_frozen i=%0d got %0d/%0d/%b want 1/2/0", i, phase, remain, tick);
            end
        end
        hold = 1'b0;
        adv(1);
        n_chk++; if (remain !== 8'd2 || tick !== 1'b0) begin n_fail++; $display("FAIL hold_resume1 got %0d/%b want 2/0", remain, tick); end
        adv(1);
        n_chk++; if (phase !== 3'd1 || remain !== 8'd1 || tick !== 1'b1) begin n_fail++; $display("FAIL hold_resume2 got %0d/%0d/%b want 1/1/1", phase, remain, tick); end
        adv(4);
        n_chk++; if (phase !== 3'd2 || remain !== 8'd1) begin n_fail++; $display("FAIL hold_allred got %0d/%0d want 2/1", phase, remain); end
    endtask

    task automatic test_reset_mid;
        do_reset(8'd0, 8'd0);
        adv(25);
        n_chk++; if (phase !== 3'd3) begin n_fail++; $display("FAIL rmid_pre got %0d want 3", phase); end
        rst = 1'b0;
        adv(1);
        rst = 1'b1;
        n_chk++; if (phase !== 3'd0 || remain !== 8'd3) begin n_fail++; $display("FAIL rmid_state got %0d/%0d want 0/3", phase, remain); end
        n_chk++; if ({light1, light3, light2, light4} !== 4'b1100) begin n_fail++; $display("FAIL rmid_lights got %b want 1100", {light1, light3, light2, light4}); end
        adv(3);
        n_chk++; if (remain !== 8'd3 || tick !== 1'b0) begin n_fail++; $display("FAIL rmid_presc got %0d/%b want 3/0", remain, tick); end
        adv(1);
        n_chk++; if (remain !== 8'd2 || tick !== 1'b1) begin n_fail++; $display("FAIL rmid_tick got %0d/%b want 2/1", remain, tick); end
    endtask

`ifdef PED_EN
    task automatic test_ped;
        do_reset(8'd0, 8'd0);
        adv(2);
        ped_req = 1'b1;
        adv(19);
        n_chk++; if (phase !== 3'd2 || ped_walk !== 1'b0) begin n_fail++; $display("FAIL ped_allred got %0d/%b want 2/0", phase, ped_walk); end
        adv(4);
        n_chk++; if (phase !== 3'd6 || remain !== 8'd2 || ped_walk !== 1'b1) begin n_fail++; $display("FAIL ped_enter got %0d/%0d/%b want 6/2/1", phase, remain, ped_walk); end
        n_chk++; if ({light1, light3, light2, light4, yellow_a, yellow_b} !== 6'b0) begin n_fail++; $display("FAIL ped_lights got %b want 000000", {light1, light3, light2, light4, yellow_a, yellow_b}); end
        ped_req = 1'b0;
        adv(2);
        ped_req = 1'b1;
        adv(2);
        n_chk++; if (phase !== 3'd6 || remain !== 8'd1) begin n_fail++; $display("FAIL ped_t7 got %0d/%0d want 6/1", phase, remain); end
        adv(4);
        n_chk++; if (phase !== 3'd3 || remain !== 8'd3 || ped_walk !== 1'b0) begin n_fail++; $display("FAIL ped_exit got %0d/%0d/%b want 3/3/0", phase, remain, ped_walk); end
        adv(20);
        n_chk++; if (phase !== 3'd5) begin n_fail++; $display("FAIL ped_b_allred got %0d want 5", phase); end
        adv(4);
        n_chk++; if (phase !== 3'd0 || ped_walk !== 1'b0) begin n_fail++; $display("FAIL ped_second_ignored got %0d/%b want 0/0", phase, ped_walk); end
    endtask
`endif

    initial begin
        rst     = 1'b0;
        hold    = 1'b0;
        queue_a = 8'd0;
        queue_b = 8'd0;
`ifdef PED_EN
        ped_req = 1'b0;
`endif
        test_reset;
        test_basic_cycle;
        test_extend_a;
        test_extend_b;
        test_hold;
        test_reset_mid;
`ifdef PED_EN
        test_ped;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
